// File: rtl/lif_pkg.sv
// Shared types and default sizing for the LIF neuron readout path.
package lif_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned CNT_W_DEF      = 8;
  localparam int unsigned ISI_W_DEF      = 8;
  localparam int unsigned WINDOW_LEN_DEF = 64;

  // Window index counter width for a window of len enabled cycles.
  function automatic int unsigned win_cnt_w(input int unsigned len);
    return $clog2(len);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear and parallel load (clear > load > inc).
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/spike_window_counter.sv
// Per-window spike count and minimum inter-spike interval, delivered on a
// valid/ready port with a sticky overrun flag for dropped results.
module spike_window_counter
  import lif_pkg::*;
#(
  parameter int unsigned WINDOW_LEN = WINDOW_LEN_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned ISI_W      = ISI_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             spike,
  input  logic             out_ready,
  input  logic             clr_overrun,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_count,
  output logic [ISI_W-1:0] out_min_isi,
  output logic             overrun
);

  localparam int unsigned WIN_W = win_cnt_w(WINDOW_LEN);
  localparam logic [WIN_W-1:0] LAST_IDX = WIN_W'(WINDOW_LEN - 1);

  state_e           state_q, state_d;
  logic [WIN_W-1:0] win_cnt_q;
  logic [CNT_W-1:0] acc_q;
  logic [ISI_W-1:0] isi_q;
  logic [ISI_W-1:0] min_q;
  logic             seen_q;

  logic             abort_c;
  logic             close_c;
  logic             isi_hit_c;
  logic [CNT_W-1:0] acc_fin_c;
  logic [ISI_W-1:0] min_fin_c;
  logic             load_c;
  logic             drop_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state plus window-level strobes; en=0 in RUN discards the window.
  always_comb begin
    state_d = state_q;
    abort_c = 1'b0;
    close_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) state_d = RUN;
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
          abort_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (en && (win_cnt_q == LAST_IDX)) close_c = 1'b1;
  end

  sat_counter #(.W(CNT_W)) u_acc (
    .clk      (clk),
    .rst      (rst),
    .clear    (abort_c | close_c),
    .load     (1'b0),
    .load_val ('0),
    .inc      (en & spike),
    .q        (acc_q)
  );

  // Distance since the previous spike; a spike restarts it at 1.
  sat_counter #(.W(ISI_W)) u_isi (
    .clk      (clk),
    .rst      (rst),
    .clear    (abort_c),
    .load     (en & spike),
    .load_val (ISI_W'(1)),
    .inc      (en & ~spike),
    .q        (isi_q)
  );

  // Final window values include the spike sampled on the closing cycle.
  assign isi_hit_c = en && spike && seen_q && (isi_q < min_q);
  assign min_fin_c = isi_hit_c ? isi_q : min_q;
  assign acc_fin_c = (en && spike && (acc_q != {CNT_W{1'b1}})) ? acc_q + 1'b1 : acc_q;
  assign load_c    = close_c && (!out_valid || out_ready);
  assign drop_c    = close_c && out_valid && !out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt_q <= '0;
      seen_q    <= 1'b0;
      min_q     <= '1;
    end else if (abort_c || close_c) begin
      win_cnt_q <= '0;
      seen_q    <= 1'b0;
      min_q     <= '1;
    end else if (en) begin
      win_cnt_q <= win_cnt_q + 1'b1;
      if (spike) seen_q <= 1'b1;
      min_q <= min_fin_c;
    end
  end

  // Result register: a load on the transfer edge keeps out_valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_count   <= '0;
      out_min_isi <= '1;
      overrun     <= 1'b0;
    end else begin
      if (load_c) begin
        out_valid   <= 1'b1;
        out_count   <= acc_fin_c;
        out_min_isi <= min_fin_c;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (drop_c)           overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spike_window_counter.sv
// Randomised and directed checks of spike_window_counter against a
// spike-list reference model (WINDOW_LEN=8, plus a CNT_W=2 instance).
module tb_spike_window_counter;

  localparam int WL = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       spike = 1'b0;
  logic       out_ready = 1'b0;
  logic       clr_overrun = 1'b0;
  logic       out_valid, overrun;
  logic [7:0] out_count, out_min_isi;
  logic       v2, ovr2;
  logic [1:0] cnt2;
  logic [7:0] min2;

  int checks = 0;
  int errors = 0;

  // Reference model state: spike positions of the open window, result port.
  int m_idx = 0;
  int m_spk[$];
  bit m_valid = 0;
  int m_cnt = 0;
  int m_cnt2 = 0;
  int m_min = 255;
  bit m_ovr = 0;

  spike_window_counter #(.WINDOW_LEN(WL), .CNT_W(8), .ISI_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .spike(spike), .out_ready(out_ready),
    .clr_overrun(clr_overrun), .out_valid(out_valid), .out_count(out_count),
    .out_min_isi(out_min_isi), .overrun(overrun)
  );

  spike_window_counter #(.WINDOW_LEN(WL), .CNT_W(2), .ISI_W(8)) dut2 (
    .clk(clk), .rst(rst), .en(en), .spike(spike), .out_ready(out_ready),
    .clr_overrun(clr_overrun), .out_valid(v2), .out_count(cnt2),
    .out_min_isi(min2), .overrun(ovr2)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_idx = 0; m_spk.delete(); m_valid = 0;
    m_cnt = 0; m_cnt2 = 0; m_min = 255; m_ovr = 0;
  endtask

  // Advance the model by one clock edge using the inputs sampled there.
  task automatic model_update();
    bit close = 0;
    int cnt = 0;
    int mn = 255;
    bit xfer = m_valid && out_ready;
    if (en) begin
      if (spike) m_spk.push_back(m_idx);
      if (m_idx == WL - 1) begin
        close = 1;
        cnt = m_spk.size();
        for (int i = 1; i < m_spk.size(); i++)
          if (m_spk[i] - m_spk[i-1] < mn) mn = m_spk[i] - m_spk[i-1];
        m_spk.delete();
        m_idx = 0;
      end else begin
        m_idx++;
      end
    end else begin
      m_spk.delete();
      m_idx = 0;
    end
    if (close && (!m_valid || out_ready)) begin
      m_valid = 1;
      m_cnt  = (cnt > 255) ? 255 : cnt;
      m_cnt2 = (cnt > 3) ? 3 : cnt;
      m_min  = mn;
    end else if (xfer) begin
      m_valid = 0;
    end
    if (close && m_valid && !out_ready && !(cnt == -1)) begin
      // dropped only when the old result was held and not accepted
    end
    if (close && !out_ready && xfer == 0 && m_valid && !(m_cnt == -1)) begin
    end
  endtask

  task automatic step(input bit e, input bit s, input bit r, input bit c);
    bit was_valid;
    en = e; spike = s; out_ready = r; clr_overrun = c;
    @(posedge clk);
    was_valid = m_valid;
    if (e && m_idx == WL - 1 && was_valid && !r) m_ovr = 1;
    else if (c) m_ovr = 0;
    model_update();
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, (i != 1), 1, 0);
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_count, out_min_isi, overrun, cnt2} !== {1'b0, 8'd0, 8'd255, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_async: got v=%0b cnt=%0d min=%0d ovr=%0b cnt2=%0d, want 0/0/255/0/0",
               out_valid, out_count, out_min_isi, overrun, cnt2);
    end
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < WL; i++) step(1, 0, 0, 0);
    checks++;
    if ({out_valid, out_count, out_min_isi, overrun} !== {1'b1, 8'd0, 8'd255, 1'b0}) begin
      errors++;
      $display("FAIL reset_empty_window: got v=%0b cnt=%0d min=%0d ovr=%0b, want 1/0/255/0",
               out_valid, out_count, out_min_isi, overrun);
    end
  endtask

  task automatic test_pattern();
    step(0, 0, 1, 0);
    for (int i = 0; i < WL; i++) step(1, (i == 0 || i == 3 || i == 4 || i == 7), 1, 0);
    checks++;
    if ({out_valid, out_count, out_min_isi, cnt2} !== {1'b1, 8'd4, 8'd1, 2'd3}) begin
      errors++;
      $display("FAIL pattern_result: got v=%0b cnt=%0d min=%0d cnt2=%0d, want 1/4/1/3",
               out_valid, out_count, out_min_isi, cnt2);
    end
    step(1, 0, 1, 0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL pattern_valid_clear: got v=%0b, want 0", out_valid);
    end
  endtask

  task automatic test_saturate();
    step(0, 0, 1, 0);
    for (int i = 0; i < WL; i++) step(1, 1, 1, 0);
    checks++;
    if ({out_valid, out_count, out_min_isi, v2, cnt2, min2} !== {1'b1, 8'd8, 8'd1, 1'b1, 2'd3, 8'd1}) begin
      errors++;
      $display("FAIL saturate: got cnt=%0d min=%0d cnt2=%0d min2=%0d, want 8/1/3/1",
               out_count, out_min_isi, cnt2, min2);
    end
  endtask

  task automatic test_backpressure();
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    for (int i = 0; i < WL; i++) step(1, (i == 1 || i == 6), 0, 0);
    checks++;
    if ({out_valid, out_count, out_min_isi, overrun} !== {1'b1, 8'd2, 8'd5, 1'b0}) begin
      errors++;
      $display("FAIL bp_first: got v=%0b cnt=%0d min=%0d ovr=%0b, want 1/2/5/0",
               out_valid, out_count, out_min_isi, overrun);
    end
    for (int i = 0; i < WL; i++) step(1, (i < 6), 0, 0);
    checks++;
    if ({out_valid, out_count, out_min_isi, overrun} !== {1'b1, 8'd2, 8'd5, 1'b1}) begin
      errors++;
      $display("FAIL bp_hold_overrun: got v=%0b cnt=%0d min=%0d ovr=%0b, want 1/2/5/1",
               out_valid, out_count, out_min_isi, overrun);
    end
    step(1, 0, 0, 1);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL bp_clr_overrun: got ovr=%0b, want 0", overrun);
    end
    for (int i = 1; i < WL; i++) step(1, (i == 2), (i == WL - 1), 0);
    checks++;
    if ({out_valid, out_count, out_min_isi, overrun} !== {1'b1, 8'd1, 8'd255, 1'b0}) begin
      errors++;
      $display("FAIL bp_load_on_xfer: got v=%0b cnt=%0d min=%0d ovr=%0b, want 1/1/255/0",
               out_valid, out_count, out_min_isi, overrun);
    end
  endtask

  task automatic test_abort();
    step(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, (i == 0 || i == 2 || i == 4), 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    for (int i = 0; i < WL - 1; i++) step(1, (i == 3), 1, 0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_result: got v=%0b, want 0", out_valid);
    end
    step(1, 0, 1, 0);
    checks++;
    if ({out_valid, out_count, out_min_isi, cnt2} !== {1'b1, 8'd1, 8'd255, 2'd1}) begin
      errors++;
      $display("FAIL abort_next_window: got v=%0b cnt=%0d min=%0d cnt2=%0d, want 1/1/255/1",
               out_valid, out_count, out_min_isi, cnt2);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 9) < 4),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) == 0));
      checks++;
      if ({out_valid, out_count, out_min_isi, overrun, v2, cnt2, min2, ovr2} !==
          {m_valid, 8'(m_cnt), 8'(m_min), m_ovr, m_valid, 2'(m_cnt2), 8'(m_min), m_ovr}) begin
        errors++;
        $display("FAIL random_cycle%0d: got v=%0b cnt=%0d min=%0d ovr=%0b cnt2=%0d, want v=%0b cnt=%0d min=%0d ovr=%0b cnt2=%0d",
                 n, out_valid, out_count, out_min_isi, overrun, cnt2,
                 m_valid, m_cnt, m_min, m_ovr, m_cnt2);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    #12 rst = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_pattern();
    test_saturate();
    test_backpressure();
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
